// File: rtl/udp_pkt_gen.sv
// Packet-stream source for the UDP/IP transmit user interface (sop/eop/vld/mty, tx_rdy backpressure).
// Define UDP_PKT_GEN_PRBS_EN for an LFSR payload instead of the incrementing-word payload.
module udp_pkt_gen #(
  parameter int DATA_W = 16,
  parameter int MTY_W  = 1,
  parameter int LEN_W  = 16,
  parameter int GAP_W  = 8,
  parameter int NUM_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic [GAP_W-1:0]  cfg_gap,
  input  logic [NUM_W-1:0]  cfg_num,
  input  logic [DATA_W-1:0] cfg_seed,
  input  logic              tx_rdy,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_sop,
  output logic              tx_eop,
  output logic              tx_vld,
  output logic [MTY_W-1:0]  tx_mty,
  output logic              busy,
  output logic [NUM_W-1:0]  pkt_cnt,
  output logic              done
);
  localparam int B = DATA_W / 8;
  localparam logic [LEN_W:0] C_B = (LEN_W+1)'(B);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_t;
  state_t r_state, w_state_nxt;

  logic [LEN_W-1:0]  r_nbeats, r_beat;
  logic [MTY_W-1:0]  r_mty;
  logic [GAP_W-1:0]  r_gap, r_gap_cnt;
  logic [NUM_W-1:0]  r_num, r_pkt_cnt;
  logic [DATA_W-1:0] r_seed;
  logic              r_stop_pend;

  logic [LEN_W-1:0]  w_len;
  logic [LEN_W:0]    w_len_x, w_nb_x;
  logic              w_send, w_last_beat, w_eop_acc, w_final;
  logic [NUM_W-1:0]  w_cnt_inc;
  logic [DATA_W-1:0] w_word;

  // Beat count and eop padding are fixed per run, so derive them once at start.
  assign w_len   = (cfg_len == '0) ? LEN_W'(1) : cfg_len;
  assign w_len_x = {1'b0, w_len};
  assign w_nb_x  = (w_len_x + C_B - 1'b1) / C_B;

  assign w_send      = (r_state == S_SEND);
  assign w_last_beat = (r_beat == r_nbeats - 1'b1);
  assign w_eop_acc   = w_send && tx_rdy && w_last_beat;
  assign w_cnt_inc   = r_pkt_cnt + 1'b1;
  assign w_final     = (r_num != '0) && (w_cnt_inc == r_num);

`ifdef UDP_PKT_GEN_PRBS_EN
  localparam int REP = (DATA_W + 15) / 16;
  logic [15:0] r_lfsr;

  function automatic logic [15:0] lfsr_seed(input logic [DATA_W-1:0] s);
    logic [15:0] v;
    v = 16'(s);
    return (v == 16'h0) ? 16'hFFFF : v;
  endfunction

  // x^16+x^14+x^13+x^11+1, Fibonacci form shifting towards the MSB
  always_ff @(posedge clk) begin
    if (!rst_n)
      r_lfsr <= '0;
    else if (r_state == S_IDLE && start)
      r_lfsr <= lfsr_seed(cfg_seed);
    else if (w_eop_acc)
      r_lfsr <= lfsr_seed(r_seed);
    else if (w_send && tx_rdy)
      r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
  end

  assign w_word = DATA_W'({REP{r_lfsr}});
`else
  logic [DATA_W-1:0] r_data;

  always_ff @(posedge clk) begin
    if (!rst_n)
      r_data <= '0;
    else if (r_state == S_IDLE && start)
      r_data <= cfg_seed;
    else if (w_eop_acc)
      r_data <= r_seed;
    else if (w_send && tx_rdy)
      r_data <= r_data + 1'b1;
  end

  assign w_word = r_data;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_nbeats    <= '0;
      r_mty       <= '0;
      r_gap       <= '0;
      r_num       <= '0;
      r_seed      <= '0;
      r_beat      <= '0;
      r_gap_cnt   <= '0;
      r_pkt_cnt   <= '0;
      r_stop_pend <= 1'b0;
    end else begin
      if (r_state == S_IDLE && start) begin
        r_nbeats    <= LEN_W'(w_nb_x);
        r_mty       <= MTY_W'(w_nb_x * C_B - w_len_x);
        r_gap       <= cfg_gap;
        r_num       <= cfg_num;
        r_seed      <= cfg_seed;
        r_beat      <= '0;
        r_pkt_cnt   <= '0;
        r_stop_pend <= 1'b0;
      end
      if (w_send) begin
        if (stop) r_stop_pend <= 1'b1;
        if (tx_rdy) begin
          if (w_last_beat) begin
            r_beat    <= '0;
            r_pkt_cnt <= w_cnt_inc;
          end else begin
            r_beat <= r_beat + 1'b1;
          end
        end
      end
      r_gap_cnt <= (r_state == S_GAP) ? r_gap_cnt + 1'b1 : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (start) w_state_nxt = S_SEND;
      S_SEND: begin
        // A stop arriving on the eop cycle itself still ends the run here.
        if (tx_rdy && w_last_beat) begin
          if (w_final || r_stop_pend || stop) w_state_nxt = S_IDLE;
          else if (r_gap == '0)              w_state_nxt = S_SEND;
          else                               w_state_nxt = S_GAP;
        end
      end
      S_GAP: begin
        if (stop)                                w_state_nxt = S_IDLE;
        else if (r_gap_cnt == r_gap - 1'b1)      w_state_nxt = S_SEND;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    tx_vld  = w_send;
    tx_sop  = w_send && (r_beat == '0);
    tx_eop  = w_send && w_last_beat;
    tx_mty  = (w_send && w_last_beat) ? r_mty : '0;
    tx_data = w_send ? w_word : '0;
    busy    = (r_state != S_IDLE);
    done    = w_eop_acc && w_final;
  end

  assign pkt_cnt = r_pkt_cnt;

endmodule

// File: tb/tb_udp_pkt_gen.sv
// Directed bench for udp_pkt_gen at DATA_W=16 (2 bytes per beat), incrementing payload build.
module tb_udp_pkt_gen;
  logic        clk = 1'b0;
  logic        rst_n, start, stop, tx_rdy;
  logic [15:0] cfg_len, cfg_num, cfg_seed;
  logic [7:0]  cfg_gap;
  logic [15:0] tx_data;
  logic        tx_sop, tx_eop, tx_vld, busy, done;
  logic [0:0]  tx_mty;
  logic [15:0] pkt_cnt;

  int n_chk = 0;
  int n_err = 0;

  udp_pkt_gen dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .cfg_len(cfg_len), .cfg_gap(cfg_gap), .cfg_num(cfg_num), .cfg_seed(cfg_seed),
    .tx_rdy(tx_rdy), .tx_data(tx_data), .tx_sop(tx_sop), .tx_eop(tx_eop),
    .tx_vld(tx_vld), .tx_mty(tx_mty), .busy(busy), .pkt_cnt(pkt_cnt), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not end, n_chk=%0d", n_chk);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One cycle of expected interface state, then advance to the next falling edge.
  task automatic cyc(input string tag, input logic v, s, e, m, input logic [15:0] d, input logic dn);
    if (v) chk(tag, {tx_vld, tx_sop, tx_eop, tx_mty, tx_data, done}, {v, s, e, m, d, dn});
    else   chk(tag, {tx_vld, done}, {1'b0, dn});
    @(negedge clk);
  endtask

  // Pulse start with a config, then scramble cfg_* to show it was latched.
  task automatic go(input logic [15:0] len, input logic [7:0] gap, input logic [15:0] num,
                    input logic [15:0] seed);
    cfg_len = len; cfg_gap = gap; cfg_num = num; cfg_seed = seed;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cfg_len = 16'h0777; cfg_gap = 8'h55; cfg_num = 16'h0009; cfg_seed = 16'hDEAD;
  endtask

  initial begin
    logic [31:0] pat;
    int k;
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; tx_rdy = 1'b1;
    cfg_len = '0; cfg_gap = '0; cfg_num = '0; cfg_seed = '0;
    repeat (2) @(negedge clk);
    chk("rst_outs", {tx_vld, tx_sop, tx_eop, tx_mty, tx_data, done, busy}, 0);
    chk("rst_pkt_cnt", pkt_cnt, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // 498 bytes -> 249 full beats, data 1..249, done on the eop beat
    go(16'd498, 8'd0, 16'd1, 16'h0001);
    for (int i = 1; i <= 249; i++)
      cyc("t1_beat", 1'b1, i == 1, i == 249, 1'b0, 16'(i), i == 249);
    chk("t1_busy", {busy, tx_vld}, 2'b00);
    chk("t1_pkt_cnt", pkt_cnt, 1);

    // 5 bytes -> 3 beats with 1 empty byte, 3 idle cycles between the two packets
    go(16'd5, 8'd3, 16'd2, 16'h0100);
    cyc("t2_p0b0", 1'b1, 1'b1, 1'b0, 1'b0, 16'h0100, 1'b0);
    cyc("t2_p0b1", 1'b1, 1'b0, 1'b0, 1'b0, 16'h0101, 1'b0);
    cyc("t2_p0b2", 1'b1, 1'b0, 1'b1, 1'b1, 16'h0102, 1'b0);
    chk("t2_cnt_gap", {busy, pkt_cnt}, {1'b1, 16'd1});
    cyc("t2_gap0", 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
    cyc("t2_gap1", 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
    cyc("t2_gap2", 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
    cyc("t2_p1b0", 1'b1, 1'b1, 1'b0, 1'b0, 16'h0100, 1'b0);
    cyc("t2_p1b1", 1'b1, 1'b0, 1'b0, 1'b0, 16'h0101, 1'b0);
    cyc("t2_p1b2", 1'b1, 1'b0, 1'b1, 1'b1, 16'h0102, 1'b1);
    chk("t2_end", {busy, tx_vld, pkt_cnt}, {2'b00, 16'd2});

    // 2 bytes -> single-beat packets back to back; a start mid-run is ignored
    go(16'd2, 8'd0, 16'd4, 16'hAAAA);
    cyc("t3_p0", 1'b1, 1'b1, 1'b1, 1'b0, 16'hAAAA, 1'b0);
    start = 1'b1; cfg_seed = 16'h1234;
    cyc("t3_p1", 1'b1, 1'b1, 1'b1, 1'b0, 16'hAAAA, 1'b0);
    start = 1'b0;
    cyc("t3_p2", 1'b1, 1'b1, 1'b1, 1'b0, 16'hAAAA, 1'b0);
    cyc("t3_p3", 1'b1, 1'b1, 1'b1, 1'b0, 16'hAAAA, 1'b1);
    chk("t3_end", {busy, tx_vld, pkt_cnt}, {2'b00, 16'd4});

    // 10-beat packet under irregular tx_rdy; expectations depend only on beats accepted
    pat = 32'b1101_1010_0011_0110_1011_0111_0101_1001;
    k = 0;
    go(16'd20, 8'd0, 16'd1, 16'h1000);
    for (int i = 0; i < 32 && k < 10; i++) begin
      tx_rdy = pat[i];
      #1;
      chk("t4_beat", {tx_vld, tx_sop, tx_eop, tx_mty, tx_data},
          {1'b1, k == 0, k == 9, 1'b0, 16'h1000 + 16'(k)});
      chk("t4_done", done, (k == 9) && tx_rdy);
      if (tx_rdy) k++;
      @(negedge clk);
    end
    tx_rdy = 1'b1;
    chk("t4_count", k, 10);
    chk("t4_end", {busy, tx_vld, pkt_cnt}, {2'b00, 16'd1});

    // continuous mode, stop during beat 5 of a 20-beat packet: packet finishes, no done
    go(16'd40, 8'd0, 16'd0, 16'h0000);
    for (int i = 0; i < 20; i++) begin
      stop = (i == 4);
      cyc("t5_beat", 1'b1, i == 0, i == 19, 1'b0, 16'(i), 1'b0);
    end
    chk("t5_end", {busy, tx_vld, done, pkt_cnt}, {3'b000, 16'd1});
    cyc("t5_no_sop", 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
    chk("t5_idle_cnt", pkt_cnt, 1);

    // reset in the middle of a packet, then a clean packet from the new seed
    go(16'd20, 8'd0, 16'd0, 16'h0055);
    cyc("t6_b0", 1'b1, 1'b1, 1'b0, 1'b0, 16'h0055, 1'b0);
    cyc("t6_b1", 1'b1, 1'b0, 1'b0, 1'b0, 16'h0056, 1'b0);
    cyc("t6_b2", 1'b1, 1'b0, 1'b0, 1'b0, 16'h0057, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t6_rst_outs", {tx_vld, tx_sop, tx_eop, tx_mty, tx_data, done, busy}, 0);
    chk("t6_rst_cnt", pkt_cnt, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t6_stay_idle", {busy, tx_vld}, 2'b00);
    go(16'd4, 8'd0, 16'd1, 16'h0077);
    cyc("t6_n0", 1'b1, 1'b1, 1'b0, 1'b0, 16'h0077, 1'b0);
    cyc("t6_n1", 1'b1, 1'b0, 1'b1, 1'b0, 16'h0078, 1'b1);
    chk("t6_end", {busy, tx_vld, pkt_cnt}, {2'b00, 16'd1});

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
